// File: rtl/pll_reset_seq.sv
// pll_reset_seq: staged active-low reset sequencer driven by the PLL lock flag.
// Filters lock chatter, holds all resets for a fixed interval, then releases
// core, peripheral and video resets in order. Loss of lock or a software
// request re-asserts all resets together.
// Optional feature macro: PLL_RESET_SEQ_LOSS_CNT_EN builds the saturating
// lock-loss counter; when undefined, lock_loss_cnt is tied to zero.
module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES = 256,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             soft_rst_req,
    output logic             rst_core_n,
    output logic             rst_periph_n,
    output logic             rst_video_n,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    localparam int unsigned MAX_A = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_C = (MAX_A > STAGE_GAP) ? MAX_A : STAGE_GAP;
    localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        FILTER,
        HOLD,
        STAGE1,
        STAGE2,
        RUN
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   core_q, core_d;
    logic                   periph_q, periph_d;
    logic                   video_q, video_d;
    logic                   ready_q, ready_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Synchronize the asynchronous PLL lock flag into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // State, shared down-counter and registered reset outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            core_q   <= 1'b0;
            periph_q <= 1'b0;
            video_q  <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            core_q   <= core_d;
            periph_q <= periph_d;
            video_q  <= video_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that they
    // change on the same edge as the state and still leave straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = FILTER;
                    cnt_d   = LOCK_LD;
                end
            end
            FILTER: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LD;
                end else if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD, STAGE1, STAGE2: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LD;
                end else if (soft_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else if (cnt_q == '0) begin
                    case (state_q)
                        HOLD:    begin state_d = STAGE1; cnt_d = GAP_LD; end
                        STAGE1:  begin state_d = STAGE2; cnt_d = GAP_LD; end
                        default: begin state_d = RUN;    cnt_d = '0;     end
                    endcase
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = LOCK_LD;
                end else if (soft_rst_req) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = LOCK_LD;
            end
        endcase

        core_d   = (state_d == STAGE1) || (state_d == STAGE2) || (state_d == RUN);
        periph_d = (state_d == STAGE2) || (state_d == RUN);
        video_d  = (state_d == RUN);
        ready_d  = (state_d == RUN);
    end

    assign rst_core_n   = core_q;
    assign rst_periph_n = periph_q;
    assign rst_video_n  = video_q;
    assign ready        = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q;
    logic             loss_inc;

    assign loss_inc = (state_q == RUN) && !locked_s;

    // Saturating count of lock losses taken from RUN; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_inc && (loss_q != '1)) begin
            loss_q <= loss_q + CNT_W'(1);
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: scoreboard bench for pll_reset_seq. A progress-based
// reference model pushes the expected outputs after every edge; a monitor
// pops and compares them on the falling edge.
module tb_pll_reset_seq;

    localparam int L    = 8;
    localparam int H    = 4;
    localparam int G    = 2;
    localparam int S    = 2;
    localparam int CW   = 2;
    localparam int PEND = L + H + 2 * G;

    logic          clk          = 1'b0;
    logic          rst_n        = 1'b0;
    logic          pll_locked   = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          rst_core_n;
    logic          rst_periph_n;
    logic          rst_video_n;
    logic          ready;
    logic [CW-1:0] lock_loss_cnt;

    pll_reset_seq #(
        .SYNC_STAGES(S),
        .LOCK_CYCLES(L),
        .HOLD_CYCLES(H),
        .STAGE_GAP  (G),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .rst_core_n   (rst_core_n),
        .rst_periph_n (rst_periph_n),
        .rst_video_n  (rst_video_n),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          core;
        logic          periph;
        logic          video;
        logic          rdy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Model state: p is the number of edges since FILTER entry (-1 = waiting
    // for lock), clamped once the whole release schedule has elapsed.
    int     p        = -1;
    int     loss     = 0;
    int     edge_idx = -1;
    bit [S-1:0] sm   = '0;
    bit     ls;

    int core_rise   = -1;
    int periph_rise = -1;
    int video_rise  = -1;

    function automatic exp_t expect_from(int prog, int lc);
        exp_t e;
        e.core   = (prog >= L + H);
        e.periph = (prog >= L + H + G);
        e.video  = (prog >= PEND);
        e.rdy    = (prog >= PEND);
        e.cnt    = CW'(lc);
        return e;
    endfunction

    // Reference model: advance the release schedule from the rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p        = -1;
            loss     = 0;
            sm       = '0;
            edge_idx = -1;
            sb.delete();
            sb.push_back(expect_from(-1, 0));
        end else begin
            ls = sm[S-1];
            sm = {sm[S-2:0], pll_locked};
            edge_idx++;
            if (p < 0) begin
                if (ls) p = 0;
            end else if (!ls) begin
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
                if (p >= PEND && loss < (1 << CW) - 1) loss++;
`endif
                p = -1;
            end else if (soft_rst_req && p >= L) begin
                p = L;
            end else if (p < PEND) begin
                p++;
            end
            sb.push_back(expect_from(p, loss));
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        exp_t got;
        if (sb.size() != 0) begin
            e   = sb.pop_front();
            got = {rst_core_n, rst_periph_n, rst_video_n, ready, lock_loss_cnt};
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs@edge%0d: got core=%b periph=%b video=%b ready=%b cnt=%0d, expected core=%b periph=%b video=%b ready=%b cnt=%0d",
                         edge_idx, got.core, got.periph, got.video, got.rdy, got.cnt,
                         e.core, e.periph, e.video, e.rdy, e.cnt);
            end
        end
        if (!rst_n) begin
            core_rise   = -1;
            periph_rise = -1;
            video_rise  = -1;
        end else begin
            if (rst_core_n   && core_rise   < 0) core_rise   = edge_idx;
            if (rst_periph_n && periph_rise < 0) periph_rise = edge_idx;
            if (rst_video_n  && video_rise  < 0) video_rise  = edge_idx;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset, then power-up with lock raised after edge 0.
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        pll_locked = 1'b1;
        cyc(24);
        chk("core_rise_edge",   core_rise,   15);
        chk("periph_rise_edge", periph_rise, 17);
        chk("video_rise_edge",  video_rise,  19);

        // Lock loss while running.
        pll_locked = 1'b0;
        cyc(4);
        pll_locked = 1'b1;
        cyc(25);

        // Single-cycle soft reset in RUN.
        soft_rst_req = 1'b1;
        cyc(1);
        soft_rst_req = 1'b0;
        cyc(12);

        // Soft reset on the same edge that sees locked_s fall.
        pll_locked = 1'b0;
        cyc(2);
        soft_rst_req = 1'b1;
        cyc(1);
        soft_rst_req = 1'b0;
        cyc(6);
        pll_locked = 1'b1;
        cyc(25);

        // Lock chatter during filtering.
        pll_locked = 1'b0;
        cyc(5);
        pll_locked = 1'b1;
        cyc(5);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        cyc(25);

        // Asynchronous reset while in STAGE1.
        soft_rst_req = 1'b1;
        cyc(1);
        soft_rst_req = 1'b0;
        cyc(4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs",
               int'({rst_core_n, rst_periph_n, rst_video_n, ready, lock_loss_cnt}), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(25);

        // Repeated losses from RUN to reach counter saturation.
        repeat (4) begin
            pll_locked = 1'b0;
            cyc(4);
            pll_locked = 1'b1;
            cyc(22);
        end

        // Randomized lock and soft-reset activity.
        repeat (800) begin
            if (pll_locked) begin
                if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 5) == 0) pll_locked = 1'b1;
            end
            soft_rst_req = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        soft_rst_req = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

Reset sequencer that consumes the `locked` flag of the board PLL and produces staged, glitch-free active-low resets for the core, peripheral and video domains. It runs on the free-running PLL reference clock (100 MHz), so it keeps working while the PLL is unlocked. It filters lock chatter, holds reset for a fixed interval, releases the domains in order, and re-enters reset on loss of lock or on a software request.

## Interface
- `SYNC_STAGES`, 2 — flops in the `pll_locked` synchronizer, ≥2
- `LOCK_CYCLES`, 1024 — consecutive cycles `locked_s` must stay high before hold starts, ≥1
- `HOLD_CYCLES`, 256 — cycles all resets stay asserted after the lock filter passes, ≥1
- `STAGE_GAP`, 16 — cycles between successive domain releases, ≥1
- `CNT_W`, 8 — width of the lock-loss counter
- `clk` in 1 — PLL reference clock, free-running
- `rst_n` in 1 — asynchronous active-low reset (one clock; asynchronous, active-low reset)
- `pll_locked` in 1 — PLL lock, asynchronous to `clk`
- `soft_rst_req` in 1 — synchronous single-cycle request to re-run the sequence
- `rst_core_n` out 1 — core reset, active-low, registered
- `rst_periph_n` out 1 — peripheral reset, active-low, registered
- `rst_video_n` out 1 — video reset, active-low, registered
- `ready` out 1 — high only in RUN
- `lock_loss_cnt` out CNT_W — saturating count of lock losses in RUN

## Operation
- `pll_locked` passes through a `SYNC_STAGES` flop chain; the last stage is `locked_s`. No logic samples `pll_locked` directly.
- One shared down-counter, sized for max(LOCK_CYCLES, HOLD_CYCLES, STAGE_GAP), reloads on every state entry.
- States:
  - WAIT_LOCK: all resets low. If `locked_s` is 1, go to FILTER.
  - FILTER: lasts LOCK_CYCLES cycles, then goes to HOLD. If `locked_s` is 0 on any cycle, go to WAIT_LOCK and restart the full count.
  - HOLD: lasts HOLD_CYCLES cycles, then go to STAGE1 and set `rst_core_n` to 1.
  - STAGE1: lasts STAGE_GAP cycles, then go to STAGE2 and set `rst_periph_n` to 1.
  - STAGE2: lasts STAGE_GAP cycles, then go to RUN and set `rst_video_n` and `ready` to 1.
  - RUN: stays until an event below occurs.
- From HOLD, STAGE1, STAGE2 and RUN, if `locked_s` is 0: go to WAIT_LOCK and drive all resets low and `ready` low on the next edge. Lock loss taken from RUN increments `lock_loss_cnt`.
- `soft_rst_req` in HOLD, STAGE1, STAGE2 or RUN: drive all resets low on the next edge and enter HOLD with a reloaded counter. It is ignored in WAIT_LOCK and FILTER.
- Lock loss and `soft_rst_req` in the same cycle: lock loss wins (WAIT_LOCK, counter increments if in RUN).
- Release order is always core, then peripheral, then video. No reset is ever released out of order. Any re-assertion drops all three together.

## Timing
- While `rst_n` is low: all outputs are 0, the synchronizer flops are 0, the state is WAIT_LOCK and `lock_loss_cnt` is 0. This takes effect asynchronously. Release is synchronous to the next edge.
- Call N the edge at which `locked_s` first reads 1. Then:
  - FILTER is entered at N+1.
  - `rst_core_n` rises at N+1+LOCK_CYCLES+HOLD_CYCLES.
  - `rst_periph_n` rises STAGE_GAP edges after `rst_core_n`.
  - `rst_video_n` and `ready` rise 2·STAGE_GAP edges after `rst_core_n`.
- Lock-loss latency from a `pll_locked` fall to all resets low is at most SYNC_STAGES+1 edges.
- Soft-reset latency is 1 edge from `soft_rst_req` to all resets low. `rst_core_n` rises again HOLD_CYCLES edges after that.
- All outputs come directly from flops, with no combinational path from any input to any output.

## Configuration
- `PLL_RESET_SEQ_LOSS_CNT_EN` defined: `lock_loss_cnt` counts RUN-to-WAIT_LOCK transitions and saturates at 2^CNT_W−1. Only `rst_n` clears it.
- Macro undefined: the counter flops are not built and `lock_loss_cnt` is tied to 0. All other behaviour is identical.

## Test plan
Parameters for all scenarios: LOCK_CYCLES=8, HOLD_CYCLES=4, STAGE_GAP=2, SYNC_STAGES=2.
- Power-up: `rst_n` released; `pll_locked` raised after edge 0 -> `rst_core_n` rises at edge 15, `rst_periph_n` at 17, `rst_video_n` and `ready` at 19.
- Chatter: `pll_locked` drops for 1 cycle at edge 6 -> FSM returns to WAIT_LOCK; `rst_core_n` rises 13 edges after the new `locked_s` rise, never earlier.
- Loss in RUN: `pll_locked` falls at edge 30 -> all resets low and `ready` low by edge 33; `lock_loss_cnt`=1 with the macro, 0 without.
- Soft reset: 1-cycle `soft_rst_req` in RUN -> all resets low at the next edge; core, periph and video release at +4, +6 and +8 edges.
- Simultaneous: `soft_rst_req` in the same cycle `locked_s` falls in RUN -> WAIT_LOCK, counter increments, and the sequence waits for lock again.
- Async reset mid-STAGE1: `rst_n` pulled low between edges -> all outputs 0 immediately and `lock_loss_cnt` cleared; after release the full sequence restarts from WAIT_LOCK.
